// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the four-digit seven-segment scan driver.
//   - Segment patterns are active low, ordered {A,B,C,D,E,F,G} from bit 6 to bit 0.
//   - NUM_DIGITS and the digit index type size the scan.
//   - scan_state_t tracks whether a first snapshot has been taken since reset.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  // SCAN_WAIT: no snapshot since clr, display dark; SCAN_RUN: normal scanning
  typedef enum logic {
    SCAN_WAIT = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to seven-segment decoder, active-low outputs.
//   bcd  in  4  BCD digit; codes 10..15 are not valid BCD
//   seg  out 7  active-low segments {A,B,C,D,E,F,G}; invalid codes show a dash
module seg7_decode import seg_pkg::*; (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Anything outside 0..9 lights only the middle bar so bad data is visible
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display4_scan.sv
// bcd_display4_scan: four-digit time-multiplexed common-anode display driver.
// Snapshots a packed BCD value once per frame and scans the digits one at a time.
//   clk    in  1   rising-edge clock
//   clr    in  1   synchronous active-high reset
//   en     in  1   scan enable; prescaler and digit index hold while low
//   blank  in  1   forces all anodes off, scanning continues underneath
//   d      in  16  packed BCD, d[15:12] thousands .. d[3:0] units
//   dp     in  4   decimal-point request per digit, active high
//   an     out 4   anode enables, active low, an[0] = units
//   seg    out 7   segments, active low, seg[6]=A .. seg[0]=G
//   dp_n   out 1   decimal point, active low
//   frame  out 1   one-cycle pulse the cycle after each snapshot
// Build option: define SEG_LZB_EN for leading-zero blanking of digits 3..1.
module bcd_display4_scan import seg_pkg::*; #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        blank,
  input  logic [15:0] d,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam int PC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(REFRESH_DIV - 1);

  logic [PC_W-1:0] pc;
  digit_idx_t      idx;
  logic [15:0]     snap_d;
  logic [3:0]      snap_dp;
  scan_state_t     state;
  scan_state_t     state_nxt;
  logic            tick;
  logic            frame_start;
  logic            show;
  logic [3:0]      cur_nib;
  logic [6:0]      dec_seg;
  logic            lz_blank;

  assign tick = en && (pc == PC_LAST);

  // State register: the "start flag" is the SCAN_WAIT state
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= SCAN_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave SCAN_WAIT on the first enabled cycle, then stay scanning
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN_WAIT: if (en) state_nxt = SCAN_RUN;
      SCAN_RUN:  state_nxt = SCAN_RUN;
      default:   state_nxt = SCAN_WAIT;
    endcase
  end

  // Frame start is either the first enabled cycle or the tick that ends the last digit;
  // the display stays dark until something has actually been snapshotted
  always_comb begin
    frame_start = 1'b0;
    show        = 1'b0;
    case (state)
      SCAN_WAIT: frame_start = en;
      SCAN_RUN: begin
        frame_start = tick && (idx == LAST_IDX);
        show        = 1'b1;
      end
      default: begin
        frame_start = 1'b0;
        show        = 1'b0;
      end
    endcase
  end

  // Prescaler and digit index; both freeze whenever en is low
  always_ff @(posedge clk) begin
    if (clr) begin
      pc  <= '0;
      idx <= '0;
    end else if (frame_start) begin
      pc  <= '0;
      idx <= '0;
    end else if (tick) begin
      pc  <= '0;
      idx <= idx + digit_idx_t'(1);
    end else if (en) begin
      pc  <= pc + PC_W'(1);
    end
  end

  // Snapshot once per frame so a value changing mid-scan never tears
  always_ff @(posedge clk) begin
    if (clr) begin
      snap_d  <= '0;
      snap_dp <= '0;
    end else if (frame_start) begin
      snap_d  <= d;
      snap_dp <= dp;
    end
  end

  assign cur_nib = snap_d[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every more significant nibble are zero;
  // the units digit always shows so that zero reads as "0"
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (snap_d[15:12] == 4'd0);
      2'd2:    lz_blank = (snap_d[15:8]  == 8'd0);
      2'd1:    lz_blank = (snap_d[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Registered outputs give a fixed one-cycle latency from idx, snapshot or blank
  always_ff @(posedge clk) begin
    if (clr) begin
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      frame <= frame_start;
      if (!show) begin
        an   <= AN_OFF;
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
      end else begin
        an   <= blank ? AN_OFF : ~(4'b0001 << idx);
        seg  <= lz_blank ? SEG_OFF : dec_seg;
        dp_n <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_bcd_display4_scan.sv
// tb_bcd_display4_scan: self-checking bench for bcd_display4_scan with REFRESH_DIV=4.
// A behavioural model tracks the position within a frame as a single enabled-cycle
// count and derives the lit digit by division; a compare process checks every cycle.
module tb_bcd_display4_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        clr;
  logic        en;
  logic        blank;
  logic [15:0] d;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  int errors = 0;
  int checks = 0;

  bcd_display4_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .blank (blank),
    .d     (d),
    .dp    (dp),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n),
    .frame (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which segments light for each code, written as letters
  string litSegs [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG",
                          "ABC", "ABCDEFG", "ABCDFG", "G", "G", "G", "G", "G", "G"};

  function automatic logic [6:0] segsFor(int v);
    logic [6:0] r;
    string s;
    int k;
    r = 7'h7F;
    s = litSegs[v];
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 65;
      r[6 - k] = 1'b0;
    end
    return r;
  endfunction

  // Behavioural model state
  bit          modelReady = 0;
  bit          started;
  int          pos;
  logic [15:0] snapD;
  logic [3:0]  snapDp;
  logic [3:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDpn;
  logic        expFrame;

  always @(posedge clk) begin : modelStep
    int digit;
    bit fs;
    bit lzb;
    if (clr) begin
      started    = 0;
      pos        = 0;
      snapD      = 16'h0;
      snapDp     = 4'h0;
      expAn      = 4'hF;
      expSeg     = 7'h7F;
      expDpn     = 1'b1;
      expFrame   = 1'b0;
      modelReady = 1;
    end else begin
      digit = pos / DIV;
      fs = en && (!started || pos == 4 * DIV - 1);
      lzb = 0;
`ifdef SEG_LZB_EN
      lzb = (digit > 0) && ((snapD >> (4 * digit)) == 16'h0);
`endif
      if (!started) begin
        expAn  = 4'hF;
        expSeg = 7'h7F;
        expDpn = 1'b1;
      end else begin
        expAn  = blank ? 4'hF : ~(4'b0001 << digit);
        expSeg = lzb ? 7'h7F : segsFor(int'((snapD >> (4 * digit)) & 16'hF));
        expDpn = ~snapDp[digit];
      end
      expFrame = fs;
      if (fs) begin
        snapD   = d;
        snapDp  = dp;
        pos     = 0;
        started = 1;
      end else if (en) begin
        pos = pos + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("model_an",    {12'h0, an},    {12'h0, expAn});
      checkOutput("model_seg",   {9'h0, seg},    {9'h0, expSeg});
      checkOutput("model_dp_n",  {15'h0, dp_n},  {15'h0, expDpn});
      checkOutput("model_frame", {15'h0, frame}, {15'h0, expFrame});
    end
  end

  task automatic applyStimulus(input logic c, input logic e, input logic b,
                               input logic [15:0] dv, input logic [3:0] dpv);
    clr   = c;
    en    = e;
    blank = b;
    d     = dv;
    dp    = dpv;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitFrame();
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (frame === 1'b1) got = 1;
    end
    checkOutput("frame_seen", {15'h0, got}, 16'h1);
  endtask

  initial begin
    logic [15:0] rv;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);

    // Reset held two cycles, then idle with en low
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    waitCycles(5);
    checkOutput("reset_an",    {12'h0, an},    16'h000F);
    checkOutput("reset_seg",   {9'h0, seg},    16'h007F);
    checkOutput("reset_dp_n",  {15'h0, dp_n},  16'h0001);
    checkOutput("reset_frame", {15'h0, frame}, 16'h0000);

    // Scan order with 1234 and dp on digit 2
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 4'b0100);
    waitCycles(1);
    checkOutput("first_frame", {15'h0, frame}, 16'h0001);
    waitCycles(1);
    checkOutput("dig0_an",  {12'h0, an},  16'h000E);
    checkOutput("dig0_seg", {9'h0, seg},  {9'h0, 7'b1001100});
    waitCycles(8);
    checkOutput("dig2_an",   {12'h0, an},   16'h000B);
    checkOutput("dig2_seg",  {9'h0, seg},   {9'h0, 7'b0010010});
    checkOutput("dig2_dp_n", {15'h0, dp_n}, 16'h0000);

    // Mid-frame change must not show until the next frame
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h5678, 4'b0000);
    waitCycles(3);
    checkOutput("dig3_an",  {12'h0, an}, 16'h0007);
    checkOutput("dig3_seg", {9'h0, seg}, {9'h0, 7'b1001111});
    waitCycles(3);
    checkOutput("second_frame", {15'h0, frame}, 16'h0001);
    waitCycles(1);
    checkOutput("new_dig0_seg", {9'h0, seg}, {9'h0, 7'b0000000});

    // Invalid BCD and blank timing
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00A9, 4'b0000);
    waitFrame();
    waitCycles(1);
    checkOutput("units9_seg", {9'h0, seg}, {9'h0, 7'b0000100});
    waitCycles(4);
    checkOutput("dash_an",  {12'h0, an}, 16'h000D);
    checkOutput("dash_seg", {9'h0, seg}, {9'h0, 7'b1111110});
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00A9, 4'b0000);
    waitCycles(1);
    checkOutput("blank_on_an", {12'h0, an}, 16'h000F);
    waitCycles(2);
    checkOutput("blank_hold_an", {12'h0, an}, 16'h000F);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00A9, 4'b0000);
    waitCycles(1);
    checkOutput("blank_off_an", {12'h0, an}, 16'h000B);

    // Freeze on digit 2, then clr while frozen
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h00A9, 4'b0000);
    waitCycles(5);
    checkOutput("frozen_an", {12'h0, an}, 16'h000B);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4321, 4'b0000);
    waitCycles(1);
    checkOutput("clr_an",    {12'h0, an},    16'h000F);
    checkOutput("clr_seg",   {9'h0, seg},    16'h007F);
    checkOutput("clr_dp_n",  {15'h0, dp_n},  16'h0001);
    checkOutput("clr_frame", {15'h0, frame}, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h4321, 4'b0000);
    waitCycles(1);
    checkOutput("rescan_frame", {15'h0, frame}, 16'h0001);
    waitCycles(1);
    checkOutput("rescan_an",  {12'h0, an}, 16'h000E);
    checkOutput("rescan_seg", {9'h0, seg}, {9'h0, 7'b1001111});

    // Leading zeros
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0007, 4'b0000);
    waitFrame();
    waitCycles(1);
    checkOutput("lz_units_seg", {9'h0, seg}, {9'h0, 7'b0001111});
    waitCycles(4);
    checkOutput("lz_tens_an", {12'h0, an}, 16'h000D);
`ifdef SEG_LZB_EN
    checkOutput("lz_tens_seg", {9'h0, seg}, 16'h007F);
`else
    checkOutput("lz_tens_seg", {9'h0, seg}, {9'h0, 7'b0000001});
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000);
    waitFrame();
    waitCycles(13);
    checkOutput("zero_thou_an", {12'h0, an}, 16'h0007);
`ifdef SEG_LZB_EN
    checkOutput("zero_thou_seg", {9'h0, seg}, 16'h007F);
`else
    checkOutput("zero_thou_seg", {9'h0, seg}, {9'h0, 7'b0000001});
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 4));
      applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                    rv, 4'($urandom));
      waitCycles(1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    waitCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
